// File: rtl/mic_level_detector_if.sv
// Read-side handshake of the audio controller: show-ahead sample FIFO with a pop strobe.
// The controller is the master; a sample consumer such as the level detector is the slave.
interface mic_level_detector_if;
    logic        audio_in_available;
    logic [31:0] left_channel_audio_in;
    logic [31:0] right_channel_audio_in;
    logic        read_audio_in;

    modport master (
        output audio_in_available,
        output left_channel_audio_in,
        output right_channel_audio_in,
        input  read_audio_in
    );

    modport slave (
        input  audio_in_available,
        input  left_channel_audio_in,
        input  right_channel_audio_in,
        output read_audio_in
    );
endinterface

// File: rtl/mic_level_detector.sv
// Pops stereo microphone samples, mixes them to mono and reports per-window peak level,
// zero-crossing count and a hold-off-limited clap pulse.
module mic_level_detector #(
    parameter int          WINDOW       = 4800,
    parameter logic [15:0] THRESH       = 16'h2000,
    parameter int          HOLD_WINDOWS = 5
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   en,
    mic_level_detector_if.slave    aud,
    output logic [15:0]            level,
    output logic [15:0]            zc_count,
    output logic                   level_valid,
    output logic                   clap
);

    localparam int              CW        = $clog2(WINDOW);
    localparam int              HW        = (HOLD_WINDOWS < 1) ? 1 : $clog2(HOLD_WINDOWS + 1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(WINDOW - 1);
    localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD_WINDOWS);

    typedef enum logic [1:0] {IDLE, POP, CALC, REPORT} state_t;

    state_t             state_q, state_d;
    logic signed [31:0] left_q, left_d, right_q, right_d;
    logic [15:0]        peak_q, peak_d, zc_q, zc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               first_q, first_d, sign_q, sign_d;
    logic               read_q, read_d;
    logic [15:0]        level_q, level_d, zc_count_q, zc_count_d;
    logic               level_valid_q, level_valid_d, clap_q, clap_d;

    logic signed [31:0] mono_s;
    logic [15:0]        abs_hi_s;
    logic               crossing_s;

    // Mono mix and upper half of |mono|; the negation is folded into the top 16 bits so
    // the most negative mono value saturates instead of wrapping.
    always_comb begin
        mono_s = (left_q >>> 1) + (right_q >>> 1);
        if (mono_s == 32'sh8000_0000) begin
            abs_hi_s = 16'h7FFF;
        end else if (mono_s[31]) begin
            abs_hi_s = ~mono_s[31:16] + {15'd0, (mono_s[15:0] == 16'h0000)};
        end else begin
            abs_hi_s = mono_s[31:16];
        end
        crossing_s = !first_q && (mono_s[31] != sign_q);
    end

    // Next-state and datapath updates for the pop/measure sequence.
    always_comb begin
        state_d       = state_q;
        left_d        = left_q;
        right_d       = right_q;
        peak_d        = peak_q;
        zc_d          = zc_q;
        cnt_d         = cnt_q;
        hold_d        = hold_q;
        first_d       = first_q;
        sign_d        = sign_q;
        read_d        = 1'b0;
        level_d       = level_q;
        zc_count_d    = zc_count_q;
        level_valid_d = 1'b0;
        clap_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!en) begin
                    peak_d  = 16'h0000;
                    zc_d    = 16'h0000;
                    cnt_d   = {CW{1'b0}};
                    first_d = 1'b1;
                end else if (aud.audio_in_available) begin
                    left_d  = aud.left_channel_audio_in;
                    right_d = aud.right_channel_audio_in;
                    read_d  = 1'b1;
                    state_d = POP;
                end else begin
                    state_d = IDLE;
                end
            end
            POP: begin
                state_d = CALC;
            end
            CALC: begin
                if (abs_hi_s > peak_q) begin
                    peak_d = abs_hi_s;
                end else begin
                    peak_d = peak_q;
                end
                if (crossing_s && (zc_q != 16'hFFFF)) begin
                    zc_d = zc_q + 16'd1;
                end else begin
                    zc_d = zc_q;
                end
                sign_d  = mono_s[31];
                first_d = 1'b0;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = REPORT;
                end else begin
                    state_d = IDLE;
                end
            end
            REPORT: begin
                level_d       = peak_q;
                zc_count_d    = zc_q;
                level_valid_d = 1'b1;
                if ((peak_q >= THRESH) && (hold_q == {HW{1'b0}})) begin
                    clap_d = 1'b1;
                    hold_d = HOLD_LOAD;
                end else if (hold_q != {HW{1'b0}}) begin
                    hold_d = hold_q - HW'(1);
                end else begin
                    hold_d = hold_q;
                end
                // The sign survives so a crossing over the window boundary is still counted.
                peak_d  = 16'h0000;
                zc_d    = 16'h0000;
                cnt_d   = {CW{1'b0}};
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            left_q        <= 32'sd0;
            right_q       <= 32'sd0;
            peak_q        <= 16'h0000;
            zc_q          <= 16'h0000;
            cnt_q         <= {CW{1'b0}};
            hold_q        <= {HW{1'b0}};
            first_q       <= 1'b1;
            sign_q        <= 1'b0;
            read_q        <= 1'b0;
            level_q       <= 16'h0000;
            zc_count_q    <= 16'h0000;
            level_valid_q <= 1'b0;
            clap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            left_q        <= left_d;
            right_q       <= right_d;
            peak_q        <= peak_d;
            zc_q          <= zc_d;
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            first_q       <= first_d;
            sign_q        <= sign_d;
            read_q        <= read_d;
            level_q       <= level_d;
            zc_count_q    <= zc_count_d;
            level_valid_q <= level_valid_d;
            clap_q        <= clap_d;
        end
    end

    assign aud.read_audio_in = read_q;
    assign level             = level_q;
    assign zc_count          = zc_count_q;
    assign level_valid       = level_valid_q;
    assign clap              = clap_q;

endmodule
